text_console_writer: RTL and testbench

- Initiator side of the text-mode character-write interface of the VGA block.
- Converts an incoming byte stream (ASCII plus a few control codes) into single-cycle character-cell write commands for a 64x24 cell grid.
- Maintains the cursor, line wrap and wrap to the top row, and clear-screen.
- Sits between the CPU/UART byte source and the VGA peripheral's charWr* inputs.

---
 rtl/text_console_writer.sv | 196 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to text-mode character-cell write commands
// Optional build macro CONSOLE_TAB_EN: TAB pads with spaces up to the next 8-column stop.
module text_console_writer #(
   parameter int          COLS     = 64,
   parameter int          ROWS     = 24,
   parameter logic [23:0] RESET_FG = 24'hFFFFFF,
   parameter logic [23:0] RESET_BG = 24'h000000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic [7:0]  inData,
   input  logic [23:0] inFg,
   input  logic [23:0] inBg,
   output logic        charWr,
   output logic [23:0] charWrFgColor,
   output logic [23:0] charWrBgColor,
   output logic [7:0]  charWrCode,
   output logic [5:0]  charWrX,
   output logic [4:0]  charWrY,
   output logic [5:0]  cursorX,
   output logic [4:0]  cursorY,
   output logic        busy
);

   localparam logic [5:0] LAST_X = 6'(COLS - 1);
   localparam logic [4:0] LAST_Y = 5'(ROWS - 1);
   localparam logic [7:0] SPACE  = 8'h20;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR, TAB} state_t;

   state_t      state;
   logic [23:0] fgLatch;
   logic [23:0] bgLatch;
   logic [5:0]  sweepX;
   logic [4:0]  sweepY;
   logic        advanceAfterWrite;
`ifdef CONSOLE_TAB_EN
   logic [23:0] tabFg;
   logic [23:0] tabBg;
`endif

   logic       accept;
   logic       isPrintable;
   logic       atOrigin;
   logic [5:0] advX;
   logic [4:0] advY;
   logic [5:0] retX;
   logic [4:0] retY;
   logic [4:0] lfY;

   assign inReady     = (state == IDLE) && !reset;
   assign accept      = inValid && inReady;
   assign isPrintable = (inData >= 8'h20) && (inData != 8'h7F);
   assign atOrigin    = (cursorX == 6'd0) && (cursorY == 5'd0);

   // Explicit compare-and-reset: ROWS is not a power of two, so no natural overflow.
   always_comb begin
      advX = (cursorX == LAST_X) ? 6'd0 : cursorX + 6'd1;
      advY = cursorY;
      if (cursorX == LAST_X)
         advY = (cursorY == LAST_Y) ? 5'd0 : cursorY + 5'd1;
      retX = (cursorX == 6'd0) ? LAST_X : cursorX - 6'd1;
      retY = cursorY;
      if (cursorX == 6'd0)
         retY = cursorY - 5'd1;
      lfY = (cursorY == LAST_Y) ? 5'd0 : cursorY + 5'd1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state             <= CLEAR;
         sweepX            <= 6'd0;
         sweepY            <= 5'd0;
         cursorX           <= 6'd0;
         cursorY           <= 5'd0;
         charWr            <= 1'b0;
         charWrCode        <= 8'd0;
         charWrX           <= 6'd0;
         charWrY           <= 5'd0;
         charWrFgColor     <= RESET_FG;
         charWrBgColor     <= RESET_BG;
         fgLatch           <= RESET_FG;
         bgLatch           <= RESET_BG;
         busy              <= 1'b0;
         advanceAfterWrite <= 1'b0;
`ifdef CONSOLE_TAB_EN
         tabFg             <= RESET_FG;
         tabBg             <= RESET_BG;
`endif
      end else begin
         charWr <= 1'b0;
         busy   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (isPrintable) begin
                     charWr            <= 1'b1;
                     charWrCode        <= inData;
                     charWrX           <= cursorX;
                     charWrY           <= cursorY;
                     charWrFgColor     <= inFg;
                     charWrBgColor     <= inBg;
                     advanceAfterWrite <= 1'b1;
                     state             <= WRITE;
                  end else begin
                     case (inData)
                        8'h0A: begin
                           cursorX <= 6'd0;
                           cursorY <= lfY;
                        end
                        8'h0D: cursorX <= 6'd0;
                        8'h08: begin
                           // Backspace blanks the cell it retreats onto; the cursor stays there.
                           if (!atOrigin) begin
                              cursorX           <= retX;
                              cursorY           <= retY;
                              charWr            <= 1'b1;
                              charWrCode        <= SPACE;
                              charWrX           <= retX;
                              charWrY           <= retY;
                              charWrFgColor     <= inFg;
                              charWrBgColor     <= inBg;
                              advanceAfterWrite <= 1'b0;
                              state             <= WRITE;
                           end
                        end
                        8'h0C: begin
                           fgLatch <= inFg;
                           bgLatch <= inBg;
                           sweepX  <= 6'd0;
                           sweepY  <= 5'd0;
                           state   <= CLEAR;
                        end
`ifdef CONSOLE_TAB_EN
                        8'h09: begin
                           tabFg <= inFg;
                           tabBg <= inBg;
                           state <= TAB;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            WRITE: begin
               if (advanceAfterWrite) begin
                  cursorX <= advX;
                  cursorY <= advY;
               end
               state <= IDLE;
            end
            CLEAR: begin
               charWr        <= 1'b1;
               busy          <= 1'b1;
               charWrCode    <= SPACE;
               charWrX       <= sweepX;
               charWrY       <= sweepY;
               charWrFgColor <= fgLatch;
               charWrBgColor <= bgLatch;
               if (sweepX == LAST_X) begin
                  sweepX <= 6'd0;
                  if (sweepY == LAST_Y) begin
                     sweepY  <= 5'd0;
                     cursorX <= 6'd0;
                     cursorY <= 5'd0;
                     state   <= IDLE;
                  end else begin
                     sweepY <= sweepY + 5'd1;
                  end
               end else begin
                  sweepX <= sweepX + 6'd1;
               end
            end
`ifdef CONSOLE_TAB_EN
            TAB: begin
               charWr        <= 1'b1;
               charWrCode    <= SPACE;
               charWrX       <= cursorX;
               charWrY       <= cursorY;
               charWrFgColor <= tabFg;
               charWrBgColor <= tabBg;
               cursorX       <= advX;
               cursorY       <= advY;
               if (advX[2:0] == 3'd0)
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - randomized self-checking bench for text_console_writer
module tb_text_console_writer;

   localparam int COLS  = 64;
   localparam int ROWS  = 24;
   localparam int CELLS = COLS * ROWS;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        inValid  = 1'b0;
   logic        inReady;
   logic [7:0]  inData   = 8'd0;
   logic [23:0] inFg     = 24'd0;
   logic [23:0] inBg     = 24'd0;
   logic        charWr;
   logic [23:0] charWrFgColor;
   logic [23:0] charWrBgColor;
   logic [7:0]  charWrCode;
   logic [5:0]  charWrX;
   logic [4:0]  charWrY;
   logic [5:0]  cursorX;
   logic [4:0]  cursorY;
   logic        busy;

   text_console_writer dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .inValid(inValid), .inReady(inReady), .inData(inData), .inFg(inFg), .inBg(inBg),
      .charWr(charWr), .charWrFgColor(charWrFgColor), .charWrBgColor(charWrBgColor),
      .charWrCode(charWrCode), .charWrX(charWrX), .charWrY(charWrY),
      .cursorX(cursorX), .cursorY(cursorY), .busy(busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int          x;
      int          y;
      int          code;
      logic [23:0] fg;
      logic [23:0] bg;
      int          cyc;
      logic        rdy;
      logic        bsy;
   } wr_t;

   wr_t wq[$];
   wr_t expQ[$];
   wr_t monW;
   int  cyc = 0;
   int  busyCycles = 0;
   int  nChecks = 0;
   int  nFails = 0;
   int  mx = 0;
   int  my = 0;

   always @(negedge CLOCK_50) begin
      cyc++;
      if (busy) busyCycles++;
      if (charWr) begin
         monW.x = int'(charWrX); monW.y = int'(charWrY); monW.code = int'(charWrCode);
         monW.fg = charWrFgColor; monW.bg = charWrBgColor; monW.cyc = cyc;
         monW.rdy = inReady; monW.bsy = busy;
         wq.push_back(monW);
      end
   end

   task automatic tick();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic model_push(input int x, input int y, input int code, input logic [23:0] fg, input logic [23:0] bg);
      wr_t w;
      w.x = x; w.y = y; w.code = code; w.fg = fg; w.bg = bg; w.cyc = 0; w.rdy = 1'b0; w.bsy = 1'b0;
      expQ.push_back(w);
   endtask

   // Cursor kept as a linear cell index; wrap is modulo the screen size.
   task automatic model_byte(input logic [7:0] b, input logic [23:0] fg, input logic [23:0] bg);
      int idx;
      idx = my * COLS + mx;
      if (b >= 8'h20 && b != 8'h7F) begin
         model_push(mx, my, int'(b), fg, bg);
         idx = (idx + 1) % CELLS;
      end else if (b == 8'h0A) begin
         idx = ((my + 1) % ROWS) * COLS;
      end else if (b == 8'h0D) begin
         idx = my * COLS;
      end else if (b == 8'h08) begin
         if (idx != 0) begin
            idx--;
            model_push(idx % COLS, idx / COLS, 32'h20, fg, bg);
         end
      end else if (b == 8'h0C) begin
         for (int i = 0; i < CELLS; i++) model_push(i % COLS, i / COLS, 32'h20, fg, bg);
         idx = 0;
      end
`ifdef CONSOLE_TAB_EN
      else if (b == 8'h09) begin
         do begin
            model_push(idx % COLS, idx / COLS, 32'h20, fg, bg);
            idx = (idx + 1) % CELLS;
         end while ((idx % COLS) % 8 != 0);
      end
`endif
      mx = idx % COLS;
      my = idx / COLS;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [23:0] fg, input logic [23:0] bg);
      int guard;
      guard = 0;
      inData = b; inFg = fg; inBg = bg; inValid = 1'b1;
      while (!inReady && guard < 4000) begin
         tick();
         guard++;
      end
      if (!inReady) begin
         nChecks++; nFails++;
         $display("FAIL handshake_timeout: inReady=%0b after %0d cycles, required 1", inReady, guard);
      end else begin
         @(posedge CLOCK_50);
      end
      tick();
      inValid = 1'b0;
      model_byte(b, fg, bg);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!inReady && guard < 4000) begin
         tick();
         guard++;
      end
      nChecks++;
      if (!inReady) begin
         nFails++;
         $display("FAIL idle_timeout: inReady=%0b, required 1", inReady);
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1;
      tick();
      nChecks++;
      if (inReady !== 1'b0 || charWr !== 1'b0) begin
         nFails++;
         $display("FAIL reset_outputs: inReady=%0b charWr=%0b, required 0 0", inReady, charWr);
      end
      tick();
      nChecks++;
      if (cursorX !== 6'd0 || cursorY !== 5'd0 || charWrCode !== 8'd0 || charWrX !== 6'd0 || charWrY !== 5'd0) begin
         nFails++;
         $display("FAIL reset_values: cursor=(%0d,%0d) code=%0h wr=(%0d,%0d), required all 0",
                  cursorX, cursorY, charWrCode, charWrX, charWrY);
      end
      wq.delete(); busyCycles = 0;
      reset = 1'b0;
      wait_idle();
      nChecks++;
      if (wq.size() != CELLS || busyCycles != CELLS) begin
         nFails++;
         $display("FAIL reset_sweep_count: writes=%0d busy=%0d, required %0d", wq.size(), busyCycles, CELLS);
      end
      bad = 0;
      for (int i = 0; i < wq.size() && i < CELLS; i++) begin
         nChecks++;
         if (wq[i].x != i % COLS || wq[i].y != i / COLS || wq[i].code != 32'h20 || wq[i].fg !== 24'hFFFFFF ||
             wq[i].bg !== 24'h000000 || wq[i].cyc != wq[0].cyc + i || wq[i].bsy !== 1'b1) begin
            nFails++;
            if (bad++ < 4)
               $display("FAIL reset_sweep[%0d]: (%0d,%0d) code=%0h bg=%0h, required (%0d,%0d) code=20 bg=0",
                        i, wq[i].x, wq[i].y, wq[i].code, wq[i].bg, i % COLS, i / COLS);
         end
      end
      nChecks++;
      if (inReady !== 1'b1 || cursorX !== 6'd0 || cursorY !== 5'd0) begin
         nFails++;
         $display("FAIL reset_end: inReady=%0b cursor=(%0d,%0d), required 1 (0,0)", inReady, cursorX, cursorY);
      end
      mx = 0; my = 0; expQ.delete();
   endtask

   task automatic test_back_to_back();
      wq.delete(); expQ.delete();
      send_byte(8'h41, 24'hFF0000, 24'h0000FF);
      send_byte(8'h42, 24'hFF0000, 24'h0000FF);
      wait_idle();
      nChecks++;
      if (wq.size() != 2) begin
         nFails++;
         $display("FAIL b2b_count: writes=%0d, required 2", wq.size());
      end else begin
         nChecks++;
         if (wq[0].x != 0 || wq[0].y != 0 || wq[0].code != 32'h41 || wq[0].fg !== 24'hFF0000 || wq[0].bg !== 24'h0000FF) begin
            nFails++;
            $display("FAIL b2b_first: (%0d,%0d) code=%0h fg=%0h bg=%0h, required (0,0) 41 ff0000 0000ff",
                     wq[0].x, wq[0].y, wq[0].code, wq[0].fg, wq[0].bg);
         end
         nChecks++;
         if (wq[1].x != 1 || wq[1].y != 0 || wq[1].code != 32'h42) begin
            nFails++;
            $display("FAIL b2b_second: (%0d,%0d) code=%0h, required (1,0) 42", wq[1].x, wq[1].y, wq[1].code);
         end
         nChecks++;
         if (wq[1].cyc - wq[0].cyc != 2) begin
            nFails++;
            $display("FAIL b2b_spacing: %0d cycles, required 2", wq[1].cyc - wq[0].cyc);
         end
         nChecks++;
         if (wq[0].rdy !== 1'b0 || wq[1].rdy !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_ready_in_write: %0b %0b, required 0 0", wq[0].rdy, wq[1].rdy);
         end
      end
      nChecks++;
      if (cursorX !== 6'd2 || cursorY !== 5'd0) begin
         nFails++;
         $display("FAIL b2b_cursor: (%0d,%0d), required (2,0)", cursorX, cursorY);
      end
   endtask

   task automatic test_row_wrap();
      send_byte(8'h0D, 24'h0, 24'h0);
      while (my != ROWS - 1) send_byte(8'h0A, 24'h0, 24'h0);
      wq.delete(); expQ.delete();
      for (int i = 0; i < COLS; i++)
         send_byte(8'($urandom_range(32, 126)), 24'($urandom), 24'($urandom));
      wait_idle();
      nChecks++;
      if (wq.size() != expQ.size() || wq.size() != COLS) begin
         nFails++;
         $display("FAIL row_wrap_count: writes=%0d, required %0d", wq.size(), COLS);
      end
      for (int i = 0; i < wq.size() && i < expQ.size(); i++) begin
         nChecks++;
         if (wq[i].x != expQ[i].x || wq[i].y != expQ[i].y || wq[i].code != expQ[i].code ||
             wq[i].fg !== expQ[i].fg || wq[i].bg !== expQ[i].bg) begin
            nFails++;
            $display("FAIL row_wrap[%0d]: (%0d,%0d) code=%0h, required (%0d,%0d) code=%0h",
                     i, wq[i].x, wq[i].y, wq[i].code, expQ[i].x, expQ[i].y, expQ[i].code);
         end
      end
      nChecks++;
      if (cursorX !== 6'd0 || cursorY !== 5'd0) begin
         nFails++;
         $display("FAIL row_wrap_cursor: (%0d,%0d), required (0,0)", cursorX, cursorY);
      end
      wq.delete();
      send_byte(8'h0A, 24'h0, 24'h0);
      wait_idle();
      nChecks++;
      if (wq.size() != 0 || cursorX !== 6'd0 || cursorY !== 5'd1) begin
         nFails++;
         $display("FAIL lf: writes=%0d cursor=(%0d,%0d), required 0 (0,1)", wq.size(), cursorX, cursorY);
      end
   endtask

   task automatic test_backspace();
      while (my != 5) send_byte(8'h0A, 24'h0, 24'h0);
      wq.delete();
      send_byte(8'h08, 24'h123456, 24'h654321);
      wait_idle();
      nChecks++;
      if (wq.size() != 1 || cursorX !== 6'd63 || cursorY !== 5'd4) begin
         nFails++;
         $display("FAIL bs_wrap: writes=%0d cursor=(%0d,%0d), required 1 (63,4)", wq.size(), cursorX, cursorY);
      end else begin
         nChecks++;
         if (wq[0].x != 63 || wq[0].y != 4 || wq[0].code != 32'h20 || wq[0].fg !== 24'h123456 || wq[0].bg !== 24'h654321) begin
            nFails++;
            $display("FAIL bs_write: (%0d,%0d) code=%0h fg=%0h bg=%0h, required (63,4) 20 123456 654321",
                     wq[0].x, wq[0].y, wq[0].code, wq[0].fg, wq[0].bg);
         end
      end
      send_byte(8'h0D, 24'h0, 24'h0);
      while (my != 0) send_byte(8'h0A, 24'h0, 24'h0);
      wq.delete();
      send_byte(8'h08, 24'h0, 24'h0);
      send_byte(8'h07, 24'h0, 24'h0);
      wait_idle();
      nChecks++;
      if (wq.size() != 0 || cursorX !== 6'd0 || cursorY !== 5'd0) begin
         nFails++;
         $display("FAIL bs_origin_bel: writes=%0d cursor=(%0d,%0d), required 0 (0,0)", wq.size(), cursorX, cursorY);
      end
   endtask

   task automatic test_tab();
      send_byte(8'h0A, 24'h0, 24'h0);
      send_byte(8'h0A, 24'h0, 24'h0);
      repeat (3) send_byte(8'h2E, 24'h0, 24'h0);
      wq.delete(); expQ.delete();
      send_byte(8'h09, 24'hABCDEF, 24'h010203);
      wait_idle();
`ifdef CONSOLE_TAB_EN
      nChecks++;
      if (wq.size() != 5 || cursorX !== 6'd8 || cursorY !== 5'd2) begin
         nFails++;
         $display("FAIL tab_first: writes=%0d cursor=(%0d,%0d), required 5 (8,2)", wq.size(), cursorX, cursorY);
      end
      for (int i = 0; i < wq.size() && i < 5; i++) begin
         nChecks++;
         if (wq[i].x != 3 + i || wq[i].y != 2 || wq[i].code != 32'h20 || wq[i].bg !== 24'h010203) begin
            nFails++;
            $display("FAIL tab_write[%0d]: (%0d,%0d) code=%0h, required (%0d,2) 20", i, wq[i].x, wq[i].y, wq[i].code, 3 + i);
         end
      end
      wq.delete();
      send_byte(8'h09, 24'h0, 24'h0);
      wait_idle();
      nChecks++;
      if (wq.size() != 8 || cursorX !== 6'd16 || cursorY !== 5'd2) begin
         nFails++;
         $display("FAIL tab_second: writes=%0d cursor=(%0d,%0d), required 8 (16,2)", wq.size(), cursorX, cursorY);
      end
`else
      nChecks++;
      if (wq.size() != 0 || cursorX !== 6'd3 || cursorY !== 5'd2) begin
         nFails++;
         $display("FAIL tab_ignored: writes=%0d cursor=(%0d,%0d), required 0 (3,2)", wq.size(), cursorX, cursorY);
      end
`endif
   endtask

   task automatic test_random();
      logic [7:0] b;
      int sel;
      wq.delete(); expQ.delete();
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 4)      b = 8'($urandom_range(32, 126));
         else if (sel == 5) b = 8'($urandom_range(128, 255));
         else if (sel == 6) b = 8'h0A;
         else if (sel == 7) b = 8'h0D;
         else if (sel == 8) b = 8'h08;
         else begin
            b = 8'($urandom_range(0, 32));
            if (b == 8'h0C) b = 8'h09;
            if (b == 8'h20) b = 8'h7F;
         end
         send_byte(b, 24'($urandom), 24'($urandom));
      end
      wait_idle();
      nChecks++;
      if (wq.size() != expQ.size()) begin
         nFails++;
         $display("FAIL random_count: writes=%0d, required %0d", wq.size(), expQ.size());
      end
      for (int i = 0; i < wq.size() && i < expQ.size(); i++) begin
         nChecks++;
         if (wq[i].x != expQ[i].x || wq[i].y != expQ[i].y || wq[i].code != expQ[i].code ||
             wq[i].fg !== expQ[i].fg || wq[i].bg !== expQ[i].bg) begin
            nFails++;
            $display("FAIL random[%0d]: (%0d,%0d) code=%0h fg=%0h, required (%0d,%0d) code=%0h fg=%0h",
                     i, wq[i].x, wq[i].y, wq[i].code, wq[i].fg, expQ[i].x, expQ[i].y, expQ[i].code, expQ[i].fg);
         end
      end
      nChecks++;
      if (int'(cursorX) != mx || int'(cursorY) != my) begin
         nFails++;
         $display("FAIL random_cursor: (%0d,%0d), required (%0d,%0d)", cursorX, cursorY, mx, my);
      end
   endtask

   task automatic test_clear_and_reset();
      int guard;
      int bad;
      wq.delete(); expQ.delete();
      send_byte(8'h5A, 24'h111111, 24'h222222);
      busyCycles = 0;
      send_byte(8'h0C, 24'h00AA00, 24'h00FF00);
      send_byte(8'h51, 24'h333333, 24'h444444);
      wait_idle();
      nChecks++;
      if (wq.size() != expQ.size() || busyCycles != CELLS) begin
         nFails++;
         $display("FAIL ff_count: writes=%0d busy=%0d, required %0d %0d", wq.size(), busyCycles, expQ.size(), CELLS);
      end
      bad = 0;
      for (int i = 0; i < wq.size() && i < expQ.size(); i++) begin
         nChecks++;
         if (wq[i].x != expQ[i].x || wq[i].y != expQ[i].y || wq[i].code != expQ[i].code ||
             wq[i].fg !== expQ[i].fg || wq[i].bg !== expQ[i].bg) begin
            nFails++;
            if (bad++ < 4)
               $display("FAIL ff[%0d]: (%0d,%0d) code=%0h bg=%0h, required (%0d,%0d) code=%0h bg=%0h",
                        i, wq[i].x, wq[i].y, wq[i].code, wq[i].bg, expQ[i].x, expQ[i].y, expQ[i].code, expQ[i].bg);
         end
      end
      wq.delete();
      send_byte(8'h0C, 24'h00AA00, 24'h00FF00);
      guard = 0;
      while (wq.size() < 700 && guard < 2000) begin
         tick();
         guard++;
      end
      reset = 1'b1;
      nChecks++;
      if (wq.size() != 700) begin
         nFails++;
         $display("FAIL ff_partial_count: writes=%0d, required 700", wq.size());
      end else begin
         nChecks++;
         if (wq[699].x != 59 || wq[699].y != 10 || wq[699].bg !== 24'h00FF00) begin
            nFails++;
            $display("FAIL ff_partial_last: (%0d,%0d) bg=%0h, required (59,10) 00ff00", wq[699].x, wq[699].y, wq[699].bg);
         end
      end
      repeat (2) tick();
      wq.delete(); busyCycles = 0;
      reset = 1'b0;
      wait_idle();
      nChecks++;
      if (wq.size() != CELLS || busyCycles != CELLS) begin
         nFails++;
         $display("FAIL restart_count: writes=%0d busy=%0d, required %0d", wq.size(), busyCycles, CELLS);
      end else begin
         nChecks++;
         if (wq[0].x != 0 || wq[0].y != 0 || wq[0].fg !== 24'hFFFFFF || wq[0].bg !== 24'h000000 ||
             wq[CELLS-1].x != 63 || wq[CELLS-1].y != 23 || wq[CELLS-1].bg !== 24'h000000) begin
            nFails++;
            $display("FAIL restart_sweep: first (%0d,%0d) bg=%0h last (%0d,%0d), required (0,0) bg=0 last (63,23)",
                     wq[0].x, wq[0].y, wq[0].bg, wq[CELLS-1].x, wq[CELLS-1].y);
         end
      end
      mx = 0; my = 0; expQ.delete();
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_row_wrap();
      test_backspace();
      test_tab();
      test_random();
      test_clear_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
